mdu_arbiter: RTL and testbench

MDU_ARBITER -- requirements
Module: mdu_arbiter

---
 rtl/mdu_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_mdu_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_arbiter.sv
// mdu_arbiter -- two-port round-robin front end for a shared multi-cycle
// multiply/divide unit, and owner of the architectural {HI,LO} register.
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   flush               aborts an operation still in EXEC
//   req_valid[1:0]      per-requester request; held until req_ready
//   req_op0/1, req_a0/1, req_b0/1   per-requester op code and operands
//   req_ready[1:0]      one-hot accept, combinational, IDLE only
//   resp_valid[1:0]     one-cycle completion pulse to the owning requester
//   hilo                architectural {HI,LO}
//   mdu_op, mdu_reg1, mdu_reg2, mdu_hilo, mdu_flush   drive the shared unit
//   mdu_ret             unit result, captured on the last EXEC cycle
//
// Optional build macro: MDU_DIV0_SHORTCUT_EN -- DIV/DIVU with b==0 skips the
// unit and completes 2 cycles after accept with hilo = {a, 32'hFFFF_FFFF}.

package mdu_pkg;
  typedef enum logic [3:0] {
    OP_MULT  = 4'd0, OP_MULTU = 4'd1, OP_MADD = 4'd2, OP_MADDU = 4'd3,
    OP_MSUB  = 4'd4, OP_MSUBU = 4'd5, OP_DIV  = 4'd6, OP_DIVU  = 4'd7,
    OP_NOP   = 4'd8
  } oper_t;
endpackage

module mdu_arbiter
  import mdu_pkg::*;
#(
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 36
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [1:0]  req_valid,
  input  logic [2:0]  req_op0,
  input  logic [2:0]  req_op1,
  input  logic [31:0] req_a0,
  input  logic [31:0] req_b0,
  input  logic [31:0] req_a1,
  input  logic [31:0] req_b1,
  output logic [1:0]  req_ready,
  output logic [1:0]  resp_valid,
  output logic [63:0] hilo,
  output oper_t       mdu_op,
  output logic [31:0] mdu_reg1,
  output logic [31:0] mdu_reg2,
  output logic [63:0] mdu_hilo,
  output logic        mdu_flush,
  input  logic [63:0] mdu_ret
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [63:0]      hilo_reg;
  oper_t            mdu_op_reg;
  logic [31:0]      mdu_reg1_reg;
  logic [31:0]      mdu_reg2_reg;
  logic             last_grant_reg;  // index of the requester granted last
  logic             owner_reg;
`ifdef MDU_DIV0_SHORTCUT_EN
  logic             div0_reg;
  logic [31:0]      div0_hi_reg;
`endif

  // Round-robin pick: a lone requester always wins; on contention the one
  // not granted last wins.
  logic [1:0] grant;
  always_comb begin
    grant = req_valid;
    if (req_valid == 2'b11)
      grant = last_grant_reg ? 2'b01 : 2'b10;
  end

  // rst is gated in so nothing can look accepted while reset is held.
  assign req_ready = (state_reg == IDLE && !flush && !rst) ? grant : 2'b00;

  logic        accept;
  logic        sel;
  logic [2:0]  sel_op;
  logic [31:0] sel_a;
  logic [31:0] sel_b;
  logic        sel_is_div;
  logic        shortcut;

  assign accept     = |req_ready;
  assign sel        = req_ready[1];
  assign sel_op     = sel ? req_op1 : req_op0;
  assign sel_a      = sel ? req_a1  : req_a0;
  assign sel_b      = sel ? req_b1  : req_b0;
  assign sel_is_div = sel_op[2] & sel_op[1];

`ifdef MDU_DIV0_SHORTCUT_EN
  assign shortcut = sel_is_div && (sel_b == 32'd0);
`else
  assign shortcut = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      hilo_reg       <= '0;
      mdu_op_reg     <= OP_NOP;
      mdu_reg1_reg   <= '0;
      mdu_reg2_reg   <= '0;
      last_grant_reg <= 1'b1;
      owner_reg      <= 1'b0;
`ifdef MDU_DIV0_SHORTCUT_EN
      div0_reg       <= 1'b0;
      div0_hi_reg    <= '0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            owner_reg      <= sel;
            last_grant_reg <= sel;
            state_reg      <= EXEC;
            if (shortcut) begin
              // One EXEC cycle with the unit left idle gives the 2-cycle
              // accept-to-response latency.
              cnt_reg <= '0;
`ifdef MDU_DIV0_SHORTCUT_EN
              div0_reg    <= 1'b1;
              div0_hi_reg <= sel_a;
`endif
            end else begin
              mdu_op_reg   <= oper_t'({1'b0, sel_op});
              mdu_reg1_reg <= sel_a;
              mdu_reg2_reg <= sel_b;
              cnt_reg      <= sel_is_div ? DIV_LOAD : MUL_LOAD;
`ifdef MDU_DIV0_SHORTCUT_EN
              div0_reg     <= 1'b0;
`endif
            end
          end
        end
        EXEC: begin
          if (flush) begin
            // Abort: hilo untouched, no response.
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            mdu_op_reg   <= OP_NOP;
            mdu_reg1_reg <= '0;
            mdu_reg2_reg <= '0;
          end else if (cnt_reg == '0) begin
`ifdef MDU_DIV0_SHORTCUT_EN
            hilo_reg <= div0_reg ? {div0_hi_reg, 32'hFFFF_FFFF} : mdu_ret;
`else
            hilo_reg <= mdu_ret;
`endif
            state_reg    <= DONE;
            mdu_op_reg   <= OP_NOP;
            mdu_reg1_reg <= '0;
            mdu_reg2_reg <= '0;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        // hilo is already committed, so flush here does not cancel the pulse.
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  // DONE lasts exactly one cycle, so decoding it gives a one-cycle pulse.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_resp
      assign resp_valid[gi] = (state_reg == DONE) && (owner_reg == 1'(gi));
    end
  endgenerate

  assign hilo      = hilo_reg;
  assign mdu_hilo  = hilo_reg;
  assign mdu_op    = mdu_op_reg;
  assign mdu_reg1  = mdu_reg1_reg;
  assign mdu_reg2  = mdu_reg2_reg;
  assign mdu_flush = flush | rst;

endmodule

// File: tb/tb_mdu_arbiter.sv
// tb_mdu_arbiter -- directed checks of mdu_arbiter with a behavioural model
// of the shared multiply/divide unit driving mdu_ret.

module tb_mdu_arbiter;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic [1:0]  req_valid;
  logic [2:0]  req_op0, req_op1;
  logic [31:0] req_a0, req_b0, req_a1, req_b1;
  logic [1:0]  req_ready, resp_valid;
  logic [63:0] hilo, mdu_hilo, mdu_ret;
  oper_t       mdu_op;
  logic [31:0] mdu_reg1, mdu_reg2;
  logic        mdu_flush;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mdu_arbiter #(.MUL_LAT(2), .DIV_LAT(36)) dut (
    .clk(clk), .rst(rst), .flush(flush), .req_valid(req_valid),
    .req_op0(req_op0), .req_op1(req_op1),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .req_ready(req_ready), .resp_valid(resp_valid), .hilo(hilo),
    .mdu_op(mdu_op), .mdu_reg1(mdu_reg1), .mdu_reg2(mdu_reg2),
    .mdu_hilo(mdu_hilo), .mdu_flush(mdu_flush), .mdu_ret(mdu_ret)
  );

  // Behavioural shared unit: result is only sampled on the last EXEC edge.
  logic [63:0] s_prod, u_prod;
  int          s_a, s_b;
  assign s_prod = {{32{mdu_reg1[31]}}, mdu_reg1} * {{32{mdu_reg2[31]}}, mdu_reg2};
  assign u_prod = {32'd0, mdu_reg1} * {32'd0, mdu_reg2};
  assign s_a    = mdu_reg1;
  assign s_b    = mdu_reg2;

  always_comb begin
    mdu_ret = 64'd0;
    case (mdu_op)
      OP_MULT:  mdu_ret = s_prod;
      OP_MULTU: mdu_ret = u_prod;
      OP_MADD:  mdu_ret = mdu_hilo + s_prod;
      OP_MADDU: mdu_ret = mdu_hilo + u_prod;
      OP_MSUB:  mdu_ret = mdu_hilo - s_prod;
      OP_MSUBU: mdu_ret = mdu_hilo - u_prod;
      OP_DIV:   if (s_b != 0) mdu_ret = {32'(s_a % s_b), 32'(s_a / s_b)};
      OP_DIVU:  if (mdu_reg2 != 0) mdu_ret = {mdu_reg1 % mdu_reg2, mdu_reg1 / mdu_reg2};
      default:  mdu_ret = 64'd0;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int port, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b);
    if (port == 0) begin
      req_op0 = op; req_a0 = a; req_b0 = b; req_valid[0] = 1'b1;
    end else begin
      req_op1 = op; req_a1 = a; req_b1 = b; req_valid[1] = 1'b1;
    end
  endtask

  // Called one cycle after the accept edge; returns cycles from accept to
  // resp_valid, or -1 if it never came.
  task automatic wait_resp(output int lat);
    lat = 1;
    while (resp_valid === 2'b00 && lat < 200) begin
      tick();
      lat++;
    end
    if (resp_valid === 2'b00) lat = -1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; req_valid = 2'b11;
    req_op0 = 3'd0; req_op1 = 3'd0; req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0;
    tick(); tick();
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b expected 00", req_ready); end
    checks++; if (resp_valid !== 2'b00) begin errors++; $display("FAIL reset_resp: got %b expected 00", resp_valid); end
    checks++; if (hilo !== 64'd0) begin errors++; $display("FAIL reset_hilo: got %h expected 0", hilo); end
    checks++; if (mdu_op !== OP_NOP || mdu_reg1 !== 32'd0 || mdu_reg2 !== 32'd0) begin
      errors++; $display("FAIL reset_unit: got op %0d r1 %h r2 %h expected NOP 0 0", mdu_op, mdu_reg1, mdu_reg2); end
    checks++; if (mdu_flush !== 1'b1) begin errors++; $display("FAIL reset_mdu_flush: got %b expected 1", mdu_flush); end
    req_valid = 2'b00;
    rst = 1'b0;
    tick();
    checks++; if (mdu_flush !== 1'b0) begin errors++; $display("FAIL idle_mdu_flush: got %b expected 0", mdu_flush); end
  endtask

  task automatic test_mult();
    int lat;
    set_req(0, 3'd0, 32'hFFFF_FFFD, 32'd5);
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL mult_ready: got %b expected 01", req_ready); end
    tick();
    req_valid = 2'b00;
    checks++; if (mdu_op !== OP_MULT || mdu_reg1 !== 32'hFFFF_FFFD || mdu_reg2 !== 32'd5) begin
      errors++; $display("FAIL mult_unit_drive: got op %0d r1 %h r2 %h expected 0 fffffffd 5", mdu_op, mdu_reg1, mdu_reg2); end
    wait_resp(lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL mult_latency: got %0d expected 3", lat); end
    checks++; if (resp_valid !== 2'b01) begin errors++; $display("FAIL mult_resp: got %b expected 01", resp_valid); end
    checks++; if (hilo !== 64'hFFFF_FFFF_FFFF_FFF1) begin errors++; $display("FAIL mult_hilo: got %h expected fffffffffffffff1", hilo); end
    checks++; if (mdu_op !== OP_NOP) begin errors++; $display("FAIL mult_done_op: got %0d expected NOP", mdu_op); end
    tick();
    checks++; if (resp_valid !== 2'b00) begin errors++; $display("FAIL mult_pulse_width: got %b expected 00", resp_valid); end
  endtask

  task automatic test_round_robin();
    int lat;
    do_reset();
    set_req(0, 3'd1, 32'hFFFF_FFFF, 32'd2);
    set_req(1, 3'd7, 32'd100, 32'd7);
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rr_first: got %b expected 01", req_ready); end
    tick();
    req_valid[0] = 1'b0;  // port 1 keeps its request pending
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL rr_busy_ready: got %b expected 00", req_ready); end
    wait_resp(lat);
    checks++; if (lat !== 3 || resp_valid !== 2'b01) begin errors++; $display("FAIL rr_multu_resp: got lat %0d resp %b expected 3 01", lat, resp_valid); end
    checks++; if (hilo !== 64'h0000_0001_FFFF_FFFE) begin errors++; $display("FAIL rr_multu_hilo: got %h expected 00000001fffffffe", hilo); end
    tick();
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL rr_second: got %b expected 10", req_ready); end
    tick();
    req_valid = 2'b00;
    wait_resp(lat);
    checks++; if (lat !== 37 || resp_valid !== 2'b10) begin errors++; $display("FAIL rr_divu_resp: got lat %0d resp %b expected 37 10", lat, resp_valid); end
    checks++; if (hilo !== {32'd2, 32'd14}) begin errors++; $display("FAIL rr_divu_hilo: got %h expected 000000020000000e", hilo); end
    tick();
    req_valid = 2'b11;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rr_alternate: got %b expected 01", req_ready); end
    req_valid = 2'b10;
    #1;
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL rr_single: got %b expected 10", req_ready); end
    req_valid = 2'b00;
    tick();
  endtask

  task automatic test_madd();
    int lat;
    set_req(0, 3'd1, 32'd2, 32'd5);
    tick();
    req_valid = 2'b00;
    wait_resp(lat);
    tick();
    checks++; if (hilo !== 64'd10) begin errors++; $display("FAIL madd_setup_hilo: got %h expected 10", hilo); end
    set_req(1, 3'd2, 32'd2, 32'd3);
    tick();
    req_valid = 2'b00;
    checks++; if (mdu_op !== OP_MADD || mdu_hilo !== 64'd10) begin errors++; $display("FAIL madd_exec1: got op %0d mdu_hilo %h expected 2 10", mdu_op, mdu_hilo); end
    tick();
    checks++; if (mdu_op !== OP_MADD || mdu_hilo !== 64'd10) begin errors++; $display("FAIL madd_exec2: got op %0d mdu_hilo %h expected 2 10", mdu_op, mdu_hilo); end
    tick();
    checks++; if (resp_valid !== 2'b10 || hilo !== 64'd16) begin errors++; $display("FAIL madd_result: got resp %b hilo %h expected 10 16", resp_valid, hilo); end
    tick();
    set_req(0, 3'd4, 32'd4, 32'd1);
    tick();
    req_valid = 2'b00;
    wait_resp(lat);
    checks++; if (lat !== 3 || hilo !== 64'd12) begin errors++; $display("FAIL msub_result: got lat %0d hilo %h expected 3 12", lat, hilo); end
    tick();
  endtask

  task automatic test_flush();
    int pulses;
    set_req(0, 3'd6, 32'd50, 32'd3);
    tick();
    req_valid = 2'b00;
    for (int i = 1; i < 10; i++) tick();  // now in EXEC cycle 10
    flush = 1'b1;
    #1;
    checks++; if (mdu_flush !== 1'b1 || req_ready !== 2'b00) begin errors++; $display("FAIL flush_exec: got mdu_flush %b ready %b expected 1 00", mdu_flush, req_ready); end
    tick();
    flush = 1'b0;
    req_valid = 2'b01;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL flush_reready: got %b expected 01", req_ready); end
    checks++; if (mdu_op !== OP_NOP) begin errors++; $display("FAIL flush_op: got %0d expected NOP", mdu_op); end
    req_valid = 2'b00;
    pulses = 0;
    for (int i = 0; i < 45; i++) begin
      tick();
      if (resp_valid !== 2'b00) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL flush_no_resp: got %0d pulses expected 0", pulses); end
    checks++; if (hilo !== 64'd12) begin errors++; $display("FAIL flush_hilo: got %h expected 12", hilo); end
    // Flush in IDLE: nothing accepted, pointer (last = port 0) unchanged.
    req_valid = 2'b11;
    flush = 1'b1;
    #1;
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL flush_idle_ready: got %b expected 00", req_ready); end
    tick();
    flush = 1'b0;
    #1;
    checks++; if (req_ready !== 2'b10 || mdu_op !== OP_NOP) begin errors++; $display("FAIL flush_idle_pointer: got ready %b op %0d expected 10 NOP", req_ready, mdu_op); end
    req_valid = 2'b00;
    tick();
  endtask

  task automatic test_flush_done();
    int lat;
    set_req(0, 3'd0, 32'd1, 32'd7);
    tick();
    req_valid = 2'b00;
    wait_resp(lat);
    flush = 1'b1;
    #1;
    checks++; if (resp_valid !== 2'b01 || hilo !== 64'd7) begin errors++; $display("FAIL flush_done: got resp %b hilo %h expected 01 7", resp_valid, hilo); end
    tick();
    flush = 1'b0;
    #1;
    checks++; if (resp_valid !== 2'b00 || hilo !== 64'd7) begin errors++; $display("FAIL flush_done_after: got resp %b hilo %h expected 00 7", resp_valid, hilo); end
  endtask

  task automatic test_reset_mid_div();
    int pulses;
    set_req(0, 3'd6, 32'd100, 32'd7);
    tick();
    req_valid = 2'b00;
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    #1;
    checks++; if (hilo !== 64'd0 || req_ready !== 2'b00 || resp_valid !== 2'b00) begin
      errors++; $display("FAIL async_reset_state: got hilo %h ready %b resp %b expected 0 00 00", hilo, req_ready, resp_valid); end
    checks++; if (mdu_op !== OP_NOP || mdu_reg1 !== 32'd0 || mdu_reg2 !== 32'd0 || mdu_flush !== 1'b1) begin
      errors++; $display("FAIL async_reset_unit: got op %0d r1 %h r2 %h flush %b expected NOP 0 0 1", mdu_op, mdu_reg1, mdu_reg2, mdu_flush); end
    tick();
    rst = 1'b0;
    req_valid = 2'b11;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL reset_pointer: got %b expected 01", req_ready); end
    req_valid = 2'b00;
    pulses = 0;
    for (int i = 0; i < 45; i++) begin
      tick();
      if (resp_valid !== 2'b00) pulses++;
    end
    checks++; if (pulses !== 0 || hilo !== 64'd0) begin errors++; $display("FAIL reset_no_resp: got %0d pulses hilo %h expected 0 0", pulses, hilo); end
  endtask

  task automatic test_div0();
    int lat;
    set_req(0, 3'd6, 32'd5, 32'd0);
    tick();
    req_valid = 2'b00;
`ifdef MDU_DIV0_SHORTCUT_EN
    checks++; if (mdu_op !== OP_NOP) begin errors++; $display("FAIL div0_op: got %0d expected NOP", mdu_op); end
    wait_resp(lat);
    checks++; if (lat !== 2 || resp_valid !== 2'b01) begin errors++; $display("FAIL div0_latency: got lat %0d resp %b expected 2 01", lat, resp_valid); end
    checks++; if (hilo !== {32'd5, 32'hFFFF_FFFF}) begin errors++; $display("FAIL div0_hilo: got %h expected 00000005ffffffff", hilo); end
`else
    checks++; if (mdu_op !== OP_DIV || mdu_reg2 !== 32'd0) begin errors++; $display("FAIL div0_op: got op %0d r2 %h expected 6 0", mdu_op, mdu_reg2); end
    wait_resp(lat);
    checks++; if (lat !== 37 || resp_valid !== 2'b01) begin errors++; $display("FAIL div0_latency: got lat %0d resp %b expected 37 01", lat, resp_valid); end
`endif
    tick();
  endtask

  initial begin
    test_reset();
    test_mult();
    test_round_robin();
    test_madd();
    test_flush();
    test_flush_done();
    test_reset_mid_div();
    test_div0();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
